// File: rtl/shotclock_display_if.sv
// Display-side bus of the shot clock: countdown digits and scan strobe in,
// multiplexed active-low seven-segment drive out.
interface shotclock_display_if;
  logic       scan_en;
  logic [3:0] s1;
  logic [3:0] s0;
  logic       zero;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output scan_en, s1, s0, zero,
    input  an, seg, dp
  );

  modport slave (
    input  scan_en, s1, s0, zero,
    output an, seg, dp
  );
endinterface

// File: rtl/shotclock_display.sv
// Four-digit multiplexed seven-segment back-end for the shot clock, with
// per-frame input snapshot, leading-zero blanking and expired-clock flashing.
module shotclock_display #(
  parameter int unsigned FLASH_SCANS = 250
) (
  input  logic                clk,
  input  logic                rst_n,
  shotclock_display_if.slave  disp
);

  localparam int unsigned IDX_W  = 2;
  localparam int unsigned FCNT_W = 10;
  localparam int unsigned DIG_W  = 4;
  localparam int unsigned SEG_W  = 7;

  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FLASH_SCANS - 1);
  localparam logic [SEG_W-1:0]  SEG_OFF   = 7'b1111111;
  localparam logic [DIG_W-1:0]  AN_OFF    = 4'b1111;

  typedef enum logic {
    VISIBLE = 1'b0,
    BLANK   = 1'b1
  } flash_e;

  logic [IDX_W-1:0]  idx_q,       idx_d;
  logic [DIG_W-1:0]  snap_s1_q,   snap_s1_d;
  logic [DIG_W-1:0]  snap_s0_q,   snap_s0_d;
  logic              snap_zero_q, snap_zero_d;
  logic [FCNT_W-1:0] fcnt_q,      fcnt_d;
  flash_e            state_q,     state_d;
  logic [DIG_W-1:0]  an_q,        an_d;
  logic [SEG_W-1:0]  seg_q,       seg_d;

  function automatic logic [SEG_W-1:0] decode(input logic [DIG_W-1:0] v);
    logic [SEG_W-1:0] s;
    s = 7'b0111111;
    case (v)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q       <= 2'd3;
      snap_s1_q   <= '0;
      snap_s0_q   <= '0;
      snap_zero_q <= 1'b0;
      fcnt_q      <= '0;
      state_q     <= VISIBLE;
      an_q        <= AN_OFF;
      seg_q       <= SEG_OFF;
    end else begin
      idx_q       <= idx_d;
      snap_s1_q   <= snap_s1_d;
      snap_s0_q   <= snap_s0_d;
      snap_zero_q <= snap_zero_d;
      fcnt_q      <= fcnt_d;
      state_q     <= state_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  // Next state: slot advance, frame-wrap snapshot, flash timing
  always_comb begin
    idx_d       = idx_q;
    snap_s1_d   = snap_s1_q;
    snap_s0_d   = snap_s0_q;
    snap_zero_d = snap_zero_q;
    fcnt_d      = fcnt_q;
    state_d     = state_q;
    if (disp.scan_en) begin
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        snap_s1_d   = disp.s1;
        snap_s0_d   = disp.s0;
        snap_zero_d = disp.zero;
      end
      // The strobe that first sees expiry is flash count 0 of a visible phase
      if (!snap_zero_d || !snap_zero_q) begin
        state_d = VISIBLE;
        fcnt_d  = '0;
      end else if (fcnt_q == FCNT_LAST) begin
        fcnt_d  = '0;
        state_d = (state_q == VISIBLE) ? BLANK : VISIBLE;
      end else begin
        fcnt_d = fcnt_q + 10'd1;
      end
    end
  end

  // Output decode for the slot being entered, using post-update state
  always_comb begin
    an_d  = an_q;
    seg_d = seg_q;
    if (disp.scan_en) begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      if (state_d == VISIBLE) begin
        case (idx_d)
          2'd0: begin
            an_d  = 4'b1110;
            seg_d = decode(snap_s0_d);
          end
          2'd1: begin
            if (snap_s1_d != 4'd0 || snap_zero_d) begin
              an_d  = 4'b1101;
              seg_d = decode(snap_s1_d);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign disp.an  = an_q;
  assign disp.seg = seg_q;
  assign disp.dp  = 1'b1;

endmodule

// File: tb/tb_shotclock_display.sv
// Randomized self-checking bench for shotclock_display against a frame-level
// behavioural model, plus directed literal checks of the display patterns.
module tb_shotclock_display;

  localparam int unsigned FS = 4;

  logic clk;
  logic rst_n;
  shotclock_display_if bus ();

  shotclock_display #(.FLASH_SCANS(FS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .disp  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] dec_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
  };

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, got, exp);
    end
  endtask

  // Model: strobe k since reset shows slot k%4; zcnt counts strobes since expiry was snapshotted
  int         k;
  int         zcnt;
  logic [3:0] m_s1, m_s0;
  logic       m_zero;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;

  always @(posedge clk) begin
    int  slot;
    bit  was, blank;
    if (!rst_n) begin
      k = 0; zcnt = 0; m_s1 = 4'd0; m_s0 = 4'd0; m_zero = 1'b0;
      exp_an = 4'b1111; exp_seg = 7'b1111111;
    end else if (bus.scan_en) begin
      slot = k % 4;
      was  = m_zero;
      if (slot == 0) begin
        m_s1 = bus.s1; m_s0 = bus.s0; m_zero = bus.zero;
      end
      if (m_zero) zcnt = was ? zcnt + 1 : 0;
      blank = m_zero && (((zcnt / FS) % 2) == 1);
      exp_an = 4'b1111; exp_seg = 7'b1111111;
      if (!blank && slot == 0) begin
        exp_an = 4'b1110; exp_seg = dec_tab[m_s0];
      end else if (!blank && slot == 1 && !(m_s1 == 4'd0 && !m_zero)) begin
        exp_an = 4'b1101; exp_seg = dec_tab[m_s1];
      end
      k++;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_an", {3'b000, bus.an}, {3'b000, exp_an});
      check("model_seg", bus.seg, exp_seg);
      check("dp", {6'd0, bus.dp}, 7'd1);
    end
  end

  task automatic strobe();
    bus.scan_en = 1'b1;
    @(negedge clk);
    bus.scan_en = 1'b0;
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) strobe();
  endtask

  task automatic align();
    for (int i = 0; i < 4 && (k % 4) != 0; i++) strobe();
  endtask

  task automatic lit(input string name, input logic [3:0] an, input logic [6:0] seg);
    check({name, "_an"}, {3'b000, bus.an}, {3'b000, an});
    check({name, "_seg"}, bus.seg, seg);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.scan_en = 1'b0; bus.s1 = 4'd0; bus.s0 = 4'd0; bus.zero = 1'b0;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    lit("reset", 4'b1111, 7'b1111111);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame 24
    bus.s1 = 4'd2; bus.s0 = 4'd4;
    strobe(); lit("s24_slot0", 4'b1110, 7'b0011001);
    strobe(); lit("s24_slot1", 4'b1101, 7'b0100100);
    strobe(); lit("s24_slot2", 4'b1111, 7'b1111111);
    strobe(); lit("s24_slot3", 4'b1111, 7'b1111111);
    strobes(4);

    // Leading zero blank
    bus.s1 = 4'd0; bus.s0 = 4'd7;
    strobe(); lit("s07_slot0", 4'b1110, 7'b1111000);
    strobe(); lit("s07_slot1", 4'b1111, 7'b1111111);
    strobes(2);

    // Mid-frame change is deferred to the next wrap
    bus.s1 = 4'd1;
    strobe(); strobe(); lit("mid_slot1", 4'b1101, 7'b1111001);
    bus.s0 = 4'd3;
    strobes(2);
    strobe(); lit("mid_next0", 4'b1110, 7'b0110000);

    // Expired flashing
    align();
    bus.s1 = 4'd0; bus.s0 = 4'd0; bus.zero = 1'b1;
    strobe(); lit("fl1_slot0", 4'b1110, 7'b1000000);
    strobe(); lit("fl2_slot1", 4'b1101, 7'b1000000);
    strobes(2);
    strobe(); lit("fl5_blank", 4'b1111, 7'b1111111);
    strobes(3);
    strobe(); lit("fl9_vis", 4'b1110, 7'b1000000);
    strobes(4); lit("fl13_blank", 4'b1111, 7'b1111111);

    // Reset during blank, with scan_en asserted
    rst_n = 1'b0; bus.scan_en = 1'b1;
    @(negedge clk);
    lit("rst_blank", 4'b1111, 7'b1111111);
    rst_n = 1'b1; bus.scan_en = 1'b0;
    strobe(); lit("post_rst0", 4'b1110, 7'b1000000);
    strobes(3);
    strobe(); lit("fl_blank2", 4'b1111, 7'b1111111);
    bus.zero = 1'b0;
    strobes(3);
    strobe(); lit("unexpire0", 4'b1110, 7'b1000000);
    strobe(); lit("unexpire1", 4'b1111, 7'b1111111);

    // Non-BCD shows dash
    align();
    bus.s1 = 4'd5; bus.s0 = 4'hC;
    strobe(); lit("dash_slot0", 4'b1110, 7'b0111111);

    // Randomized traffic, including held strobes and occasional resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) bus.s1 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) bus.s0 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) bus.zero = ~bus.zero;
      if ($urandom_range(0, 3) == 0) bus.scan_en = ~bus.scan_en;
      rst_n = ($urandom_range(0, 599) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1; bus.scan_en = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shotclock_display.md
# shotclock_display

Display back-end for the shot clock: consumes the two BCD digits and the `zero` flag produced by the countdown counter, plus the `scan_en` strobe from the clock divider, and drives the 4-digit active-low seven-segment display. Time-multiplexes the four anodes, blanks the unused upper digits, and suppresses the leading zero of the tens digit. Flashes "00" while the clock is expired. Latches its inputs once per scan frame so a count change never tears mid-frame.

## Interface
- `FLASH_SCANS`, default 250: `scan_en` strobes per flash half-period. This gives 2 Hz blink at a 1 kHz scan rate. Legal range is 2..1023.
- `clk` input 1: system clock (100 MHz).
- `rst_n` input 1: one clock; reset is synchronous and active-low.
- `scan_en` input 1: single-cycle digit-advance strobe. Every cycle it is high counts as one strobe.
- `s1` input 4: tens digit, BCD.
- `s0` input 4: units digit, BCD.
- `zero` input 1: counter expired.
- `an` output 4: anode enables, active-low. `an[0]` is the rightmost digit.
- `seg` output 7: segments, active-low. `seg[6]`=g … `seg[0]`=a.
- `dp` output 1: decimal point, active-low. Tied high (off).

## Operation
- Digit index `idx` (2 bits) advances only on `scan_en`, in the order 3→0→1→2→3. On each strobe the outputs show the digit for the new `idx`.
- Snapshot: on a strobe where `idx`==3 (wrap to 0), capture `s1`, `s0`, `zero` into `snap_s1`, `snap_s0`, `snap_zero`.
  - The digit-0 output on that same strobe already uses the newly captured values.
  - Digits 1..3 of the frame use the snapshot.
- Per-slot output:
  - idx 0: `an`=1110, `seg`=decode(`snap_s0`).
  - idx 1: `an`=1101, `seg`=decode(`snap_s1`). Exception: if `snap_s1`==0 and `snap_zero`==0, output `an`=1111, `seg`=1111111 (leading-zero blank).
  - idx 2, 3: `an`=1111, `seg`=1111111.
- Decode table, value → `seg`:
  - 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001
  - 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000
  - 10..15→0111111 (dash, g only)
- Flash FSM, states VISIBLE and BLANK, with 10-bit counter `fcnt`:
  - While `snap_zero`==0: state=VISIBLE, `fcnt`=0.
  - While `snap_zero`==1, each strobe: if `fcnt`==FLASH_SCANS-1, then `fcnt`←0 and toggle state; else `fcnt`++.
  - In BLANK, `an` is forced to 1111 and `seg` to 1111111 for all slots.
  - On a `snap_zero` 0→1 transition, start in VISIBLE with `fcnt`=0.
- `dp` is constant 1.

## Timing
- All outputs are registered. They update on the clock edge following the cycle in which `scan_en`=1, and hold between strobes.
- Input-to-display latency: captured at the next frame wrap. Worst case is 4 strobes plus 1 cycle.
- Reset values (synchronous, `rst_n`=0 at an edge): `idx`=3, `an`=1111, `seg`=1111111, `dp`=1, snapshot=0, `fcnt`=0, state=VISIBLE.
- Reset mid-frame or mid-flash: all of the above take effect at the next edge. The first strobe after reset shows digit 0.
- `scan_en` asserted during reset is ignored.
- If `scan_en` is held high for N cycles, it produces N advances. There is no edge detection.
- `s1`, `s0`, `zero` changes between wraps have no visible effect until the next wrap.
- The BLANK/VISIBLE toggle is evaluated on the same strobe as the slot advance. The new slot output reflects the post-toggle state.

## Test plan
- Reset, then `s1`=2, `s0`=4, `zero`=0, 8 strobes → `an` sequence 1110,1101,1111,1111 repeated; `seg` 0011001 on slot 0, 0100100 on slot 1, 1111111 otherwise; `dp`=1 throughout.
- `s1`=0, `s0`=7 → slot 0 shows 1111000; slot 1 shows `an`=1111, `seg`=1111111 (leading zero blanked).
- Set `s0`=3 while `idx`=1 (mid-frame) → slots 1..3 unchanged; the change appears on slot 0 of the next frame only.
- `FLASH_SCANS`=4, `s1`=`s0`=0, `zero`=1:
  - slots 0 and 1 show 1000000 with `an` 1110/1101 for 4 strobes;
  - then all-blank for 4 strobes;
  - then visible again;
  - deasserting `zero` returns to VISIBLE at the next wrap.
- `s0`=4'hC → slot 0 `seg`=0111111.
- Assert `rst_n`=0 during a BLANK phase → next edge gives `an`=1111, `seg`=1111111; the first post-reset strobe shows slot 0 visible.
